segment_driver: RTL
===================

# segment_driver

- Output stage between the 4-digit hex display controller and the board's 7-segment pins.
- Consumes the controller's active-high, one-hot `anodes` and active-high `segments`, and registers them so no combinational glitches reach the pins.
- Inserts a programmable dead-time blank on every digit switch to suppress ghosting, applies optional PWM brightness, and drives pin-polarity outputs.

## Interface
- `DEAD_CYCLES`, 64: blank cycles inserted on each anode change; legal range ≥1.
- `PWM_PRESCALE`, 256: clk cycles per PWM step; legal range ≥2.
- `ACTIVE_LOW`, 1: 1 means the `an`/`seg` pins are active-low; 0 means active-high.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `anodes_in`  in  4  digit select from the display controller; active-high, one-hot expected.
- `segments_in`  in  7  segment pattern `abcdefg`, active-high.
- `brightness`  in  4  duty level 0–15.
- `an`  out  4  anode pins, at `ACTIVE_LOW` polarity.
- `seg`  out  7  segment pins, at `ACTIVE_LOW` polarity.
- `blanking`  out  1  high while the FSM is in IDLE or BLANK.

## Operation
- **Input stage:** `anodes_in`, `segments_in` and `brightness` are registered every cycle into `anodes_q`, `segments_q` and `bright_q`.
- **FSM states:** IDLE, BLANK, ON.
- **Held registers:**
  - `cur_anode` (4 bits): the digit being shown.
  - `dead_cnt`: sized to hold `DEAD_CYCLES`.
- **"Valid":** `anodes_q` has exactly one bit set.
- **IDLE:**
  - Outputs off.
  - On `anodes_q` valid: `cur_anode <= anodes_q`, `dead_cnt <= DEAD_CYCLES-1`, go to BLANK.
- **BLANK:**
  - Outputs off.
  - `anodes_q` invalid: go to IDLE.
  - `anodes_q` valid and different from `cur_anode`: latch it, reload `dead_cnt`, stay in BLANK (dead time restarts).
  - Otherwise, with `dead_cnt == 0`: go to ON.
  - Otherwise: decrement `dead_cnt`.
- **ON:**
  - `anodes_q` invalid: go to IDLE.
  - Valid and different from `cur_anode`: latch it, reload `dead_cnt`, go to BLANK.
  - Otherwise: stay in ON. `an` shows `cur_anode` and `seg` shows `segments_q`, both gated by the PWM enable.
- **PWM:**
  - `pre_cnt` counts 0..`PWM_PRESCALE`-1 and wraps.
  - `pwm_step` counts 0..14. It advances when `pre_cnt` wraps; it wraps from 14 to 0.
  - `pwm_on = (pwm_step < bright_q)`.
  - Brightness 0 gives always off, 15 gives always on, and N gives N/15 duty.
  - PWM counters free-run in every state; they are never reset by state changes.
- **Polarity:**
  - "Off" means `an`=4'b1111 and `seg`=7'b1111111 when `ACTIVE_LOW`=1; all zeros otherwise.
  - "Active" pin values are the logical values, inverted when `ACTIVE_LOW`=1.
- **Segment changes:** a segment change without an anode change never causes a blank.

## Timing
- **Reset (async assert):**
  - State IDLE; all counters 0; all input registers 0.
  - `an`/`seg` off; `blanking`=1.
- **Registered outputs:** `an`, `seg` and `blanking` are registered; no combinational path from inputs to pins.
- **Anode-change latency:**
  - Input captured at edge E0.
  - Outputs off after E1.
  - New digit visible after E1+`DEAD_CYCLES`.
  - Exactly `DEAD_CYCLES` cycles of blank.
- **Segment-only change in ON:** visible after E1, i.e. 2 edges from input change.
- **Brightness change:** takes effect 2 edges after the input change.
- **Invalid anode (0 or multi-hot):** outputs off after E1.
- **Reset mid-BLANK or mid-ON:** outputs off immediately, asynchronously; restart from IDLE.

## Configuration
- **`SEG_DRIVER_PWM_EN` defined:** PWM counters and gating exist as described.
- **`SEG_DRIVER_PWM_EN` undefined:**
  - `brightness` is ignored and no PWM counters are synthesized.
  - `pwm_on` is constant 1.
  - All other behaviour is identical.

## Structure
- **Package `seg_pkg`:**
  - FSM state enum (IDLE, BLANK, ON).
  - `PWM_STEPS`=15.
  - Helper function `is_onehot4`.
- **Sub-module `seg_pwm_gen`:** prescaler plus step counter plus compare.
  - Inputs: `clk`, `rst`, `bright_q`.
  - Output: `pwm_on`.
  - Instantiated only under `SEG_DRIVER_PWM_EN`.

## Test plan
- **Reset:** hold `rst`=1 → `an`=4'b1111, `seg`=7'b1111111, `blanking`=1. Release, apply `anodes_in`=4'b0001, `segments_in`=7'b1111110, brightness 15 → blank for exactly 64 cycles, then `an`=4'b1110, `seg`=7'b0000001.
- **Digit switch:** in ON, switch `anodes_in` to 4'b0010 → outputs off after 1 edge, for 64 cycles; `blanking` high during that window; then `an`=4'b1101.
- **Dead-time restart:** change anode again 10 cycles into BLANK → dead time restarts; total blank is 10+64 cycles.
- **Invalid anode:** `anodes_in`=4'b0011, then 4'b0000 → IDLE, outputs off. Return to 4'b0100 → full 64-cycle blank before display.
- **Segment-only change:** in ON, `segments_in` 7'b0110000 → 7'b1101101 with the anode unchanged → `seg` updates 2 edges later with no blank cycle.
- **PWM duty (`PWM_PRESCALE`=2, macro on):**
  - Brightness 5 → display active exactly 10 of every 30 cycles.
  - Brightness 0 → never active.
  - Brightness 15 → always active.
  - Macro off → always active regardless of brightness.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared types and helpers for the 7-segment output stage.
//   seg_state_e : output FSM states (IDLE, BLANK, ON)
//   PWM_STEPS   : number of brightness steps in one PWM period
//   is_onehot4  : true when a 4-bit digit select has exactly one bit set
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } seg_state_e;

  localparam int PWM_STEPS = 15;

  // v & (v-1) clears the lowest set bit; zero afterwards means at most one bit was set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/seg_pwm_gen.sv
// seg_pwm_gen: brightness PWM for the segment output stage.
//   A prescaler divides clk by PWM_PRESCALE; every prescaler wrap advances a
//   step counter 0..PWM_STEPS-1. The display is enabled while step < bright_q,
//   so level N gives N/15 duty (0 = dark, 15 = always lit).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bright_q  : registered brightness level 0..15
//   pwm_on    : enable for the display pins
module seg_pwm_gen
  import seg_pkg::*;
#(
  parameter int PWM_PRESCALE = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bright_q,
  output logic       pwm_on
);

  localparam int PW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(PWM_PRESCALE - 1);
  localparam logic [3:0]    STEP_MAX = 4'(PWM_STEPS - 1);

  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [3:0]    pwm_step_q, pwm_step_d;
  logic          pre_wrap;

  always_comb begin
    pre_wrap   = (pre_cnt_q == PRE_MAX);
    pre_cnt_d  = pre_wrap ? '0 : pre_cnt_q + PW'(1);
    pwm_step_d = pwm_step_q;
    if (pre_wrap) begin
      pwm_step_d = (pwm_step_q == STEP_MAX) ? 4'd0 : pwm_step_q + 4'd1;
    end
  end

  // Free-running: never cleared by display state changes, only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q  <= '0;
      pwm_step_q <= 4'd0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      pwm_step_q <= pwm_step_d;
    end
  end

  assign pwm_on = (pwm_step_q < bright_q);

endmodule

// File: rtl/segment_driver.sv
// segment_driver: output stage between the hex display controller and the
// board's 7-segment pins.
//   - Registers anodes/segments/brightness so no glitches reach the pins.
//   - Inserts DEAD_CYCLES blank cycles on every digit switch (anti-ghosting).
//   - Optional PWM brightness when SEG_DRIVER_PWM_EN is defined; otherwise the
//     brightness input is ignored and the display is always fully on.
//   - Pins use ACTIVE_LOW polarity (1 = active-low pins).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   anodes_in    : one-hot active-high digit select
//   segments_in  : active-high segment pattern abcdefg
//   brightness   : duty level 0..15
//   an, seg      : registered pin outputs at pin polarity
//   blanking     : registered, high while the FSM is in IDLE or BLANK
//   dbg_state_o  : current FSM state (seg_state_e encoding)
module segment_driver
  import seg_pkg::*;
#(
  parameter int DEAD_CYCLES  = 64,
  parameter int PWM_PRESCALE = 256,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] anodes_in,
  input  logic [6:0] segments_in,
  input  logic [3:0] brightness,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       blanking,
  output logic [1:0] dbg_state_o
);

  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam logic [DW-1:0] DEAD_RELOAD = DW'(DEAD_CYCLES - 1);
  localparam logic [3:0]    AN_OFF  = ACTIVE_LOW ? 4'hF  : 4'h0;
  localparam logic [6:0]    SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

  // Input stage
  logic [3:0] anodes_q;
  logic [6:0] segments_q;
  logic [3:0] bright_q;

  // FSM and held registers
  seg_state_e    state_q, state_d;
  logic [3:0]    cur_anode_q, cur_anode_d;
  logic [DW-1:0] dead_cnt_q, dead_cnt_d;

  // Registered pins
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       blanking_q, blanking_d;

  logic anode_valid;
  logic anode_new;
  logic pwm_on;

`ifdef SEG_DRIVER_PWM_EN
  seg_pwm_gen #(
    .PWM_PRESCALE(PWM_PRESCALE)
  ) u_pwm (
    .clk      (clk),
    .rst      (rst),
    .bright_q (bright_q),
    .pwm_on   (pwm_on)
  );
`else
  // Without PWM the display is always fully on; brightness is not used.
  logic unused_pwm_cfg;
  assign unused_pwm_cfg = ^{bright_q, 32'(PWM_PRESCALE)};
  assign pwm_on = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    cur_anode_d = cur_anode_q;
    dead_cnt_d  = dead_cnt_q;
    anode_valid = is_onehot4(anodes_q);
    anode_new   = (anodes_q != cur_anode_q);

    case (state_q)
      IDLE: begin
        if (anode_valid) begin
          cur_anode_d = anodes_q;
          dead_cnt_d  = DEAD_RELOAD;
          state_d     = BLANK;
        end
      end
      BLANK: begin
        if (!anode_valid) begin
          state_d = IDLE;
        end else if (anode_new) begin
          // Another switch during the dead time restarts it in full.
          cur_anode_d = anodes_q;
          dead_cnt_d  = DEAD_RELOAD;
        end else if (dead_cnt_q == '0) begin
          state_d = ON;
        end else begin
          dead_cnt_d = dead_cnt_q - DW'(1);
        end
      end
      ON: begin
        if (!anode_valid) begin
          state_d = IDLE;
        end else if (anode_new) begin
          cur_anode_d = anodes_q;
          dead_cnt_d  = DEAD_RELOAD;
          state_d     = BLANK;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pins are computed from the next state so they change on the same edge
    // as the FSM; segment-only changes pass straight through while in ON.
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if ((state_d == ON) && pwm_on) begin
      an_d  = ACTIVE_LOW ? ~cur_anode_d : cur_anode_d;
      seg_d = ACTIVE_LOW ? ~segments_q  : segments_q;
    end
    blanking_d = (state_d != ON);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anodes_q    <= 4'd0;
      segments_q  <= 7'd0;
      bright_q    <= 4'd0;
      state_q     <= IDLE;
      cur_anode_q <= 4'd0;
      dead_cnt_q  <= '0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
      blanking_q  <= 1'b1;
    end else begin
      anodes_q    <= anodes_in;
      segments_q  <= segments_in;
      bright_q    <= brightness;
      state_q     <= state_d;
      cur_anode_q <= cur_anode_d;
      dead_cnt_q  <= dead_cnt_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      blanking_q  <= blanking_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign blanking    = blanking_q;
  assign dbg_state_o = state_q;

endmodule
